imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the fetch stage's PC address. Fetch presents a byte address and a request. On a hit in the single-entry word buffer, the responder returns a 32-bit instruction one cycle later. On a miss, it stalls fetch while it assembles the word from a byte-wide backing memory with 1-cycle read latency. A writeback redirect (flush) aborts any in-flight fill.

## Interface
- WIDTH, 8, address width in bits; matches the fetch-stage PC width.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  fetch requests the instruction at addr this cycle.
- addr  input  WIDTH  byte address of the instruction (the fetch PC).
- flush  input  1  redirect from writeback; cancels the acceptance or fill in progress.
- mem_rd  output  1  backing-memory read strobe.
- mem_addr  output  WIDTH  backing-memory byte address.
- mem_rdata  input  8  byte returned in the cycle after mem_rd.
- instr  output  32  instruction word (little-endian assembly).
- instr_valid  output  1  instr belongs to the request accepted at the previous edge.
- stall  output  1  fetch must hold PC and req this cycle.

## Operation
- State: FSM {IDLE, FILL}, 3-bit cnt (0..4), base register, tag register, tag_valid, 32-bit line buffer.
- hit = tag_valid & (addr == tag).
- stall = (state == FILL) | (state == IDLE & req & ~hit & ~flush).
- Accept occurs at an edge in IDLE where req & hit & ~flush.
  - On accept: instr <= line; instr_valid <= 1.
  - Otherwise instr_valid <= 0.
- Miss: at an edge in IDLE where req & ~hit & ~flush:
  - base <= addr, cnt <= 0, state <= FILL.
- FILL, cnt = k, issue side (k = 0..3):
  - mem_rd = 1.
  - mem_addr = base + k, modulo 2^WIDTH (wraps: base FE reads FE, FF, 00, 01).
- FILL, cnt = k, capture side (k = 1..4):
  - mem_rdata is written into byte lane k-1 of the line buffer.
  - Byte at base goes to [7:0]; byte at base+3 goes to [31:24].
- FILL with cnt = 4: mem_rd = 0.
  - At that edge: tag <= base, tag_valid <= 1, state <= IDLE.
  - The completed fill does not pulse instr_valid. Fetch re-presents the held address, which then hits.
- flush, any state, at an edge:
  - state <= IDLE, cnt <= 0, instr_valid <= 0.
  - Partial fill is discarded; tag, tag_valid and line buffer are left unchanged.
- mem_rd = 0 and mem_addr = base whenever state is IDLE.
- req is ignored in FILL; fetch is stalled during that time.

## Timing
- Reset (reset = 0, applied asynchronously):
  - state IDLE, cnt 0, base 0, tag 0, tag_valid 0, line 0.
  - instr 0, instr_valid 0, mem_rd 0, mem_addr 0.
  - stall is forced to 0 while reset is low.
- Hit latency: accept at edge E, instr_valid high for the cycle after E.
- Back-to-back hits: one instr per cycle.
- Miss latency, measured from the miss edge E0:
  - FILL spans the cycles after E0..E4; the line loads at E5.
  - The re-presented address is accepted at E5+1 = E6; instr_valid is high in the cycle after E6.
  - stall is high for 6 cycles: the miss cycle plus 5 FILL cycles.
- Simultaneous events:
  - flush beats req.
  - flush in the cycle a fill would complete (cnt = 4) still aborts; tag is not updated.
- Reset released mid-operation resumes from IDLE with an empty buffer.

## Test plan
- Cold miss:
  - Stimulus: reset, then req with addr 00; memory 00..03 = 13, 05, A0, 00.
  - Required: stall high 6 cycles; mem_addr sequence 00, 01, 02, 03 with mem_rd high.
  - Required: instr = 0x00A00513 with instr_valid high in the cycle after the re-accept.
- Hit streaming: after the cold miss, hold req with addr 00 for 4 cycles -> stall 0; instr_valid high 4 consecutive cycles; mem_rd stays 0.
- Wrap-around:
  - Stimulus: req with addr FE; memory FE = 11, FF = 22, 00 = 33, 01 = 44.
  - Required: mem_addr FE, FF, 00, 01; instr = 0x44332211.
- Flush mid-fill:
  - Stimulus: line holding addr 00, then miss on addr 10, flush at cnt = 2.
  - Required: state IDLE next cycle; no instr_valid.
  - Required: a later req with addr 00 hits (stall 0); req with addr 10 misses again.
- Flush vs hit: req with addr 00 hitting, flush high the same cycle -> instr_valid 0 next cycle; stall 0.
- Async reset mid-fill:
  - Stimulus: drop reset at cnt = 3.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Required: after release, req with addr 00 misses (tag_valid cleared).

Source files
------------

// File: rtl/imem_responder.sv
`timescale 1ns/1ps
// imem_responder: single-entry word buffer in front of a byte-wide instruction memory
//   clk, reset                  clock; asynchronous active-low reset
//   req, addr, flush            fetch request, fetch PC (byte address), writeback redirect
//   mem_rd, mem_addr, mem_rdata backing-memory port; data returns the cycle after mem_rd
//   instr, instr_valid, stall   little-endian instruction word, its valid flag, fetch hold
module imem_responder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [WIDTH-1:0] addr,
    input  logic             flush,
    output logic             mem_rd,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [7:0]       mem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             stall
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;
    logic [0:0]       r_state;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_tag;
    logic             r_tag_valid;
    logic [31:0]      r_line;
    // bytes of an in-flight fill are assembled here so an aborted fill never disturbs r_line
    logic [23:0]      r_fill;
    logic             w_hit;
    logic             w_idle;
    logic             w_miss;
    logic             w_accept;
    assign w_hit    = r_tag_valid & (addr == r_tag);
    assign w_idle   = r_state == IDLE;
    assign w_miss   = w_idle & req & ~w_hit & ~flush;
    assign w_accept = w_idle & req & w_hit & ~flush;
    assign mem_rd   = (r_state == FILL) & (r_cnt != 3'd4);
    // r_cnt is zero whenever IDLE, so this also yields base while idle
    assign mem_addr = r_base + WIDTH'(r_cnt);
    assign stall    = reset & ((r_state == FILL) | w_miss);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_base      <= '0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_line      <= '0;
            r_fill      <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= w_accept;
            if (w_accept) instr <= r_line;
            if (flush) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (w_miss) begin
                r_base  <= addr;
                r_cnt   <= '0;
                r_state <= FILL;
            end else if (r_state == FILL) begin
                // shift bytes in from the top: after three captures r_fill = {b2, b1, b0}
                r_fill <= {mem_rdata, r_fill[23:8]};
                r_cnt  <= (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
                if (r_cnt == 3'd4) begin
                    r_line      <= {mem_rdata, r_fill};
                    r_tag       <= r_base;
                    r_tag_valid <= 1'b1;
                    r_state     <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
`timescale 1ns/1ps
// tb_imem_responder: randomized + directed bench against a fill-countdown reference model
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [7:0]  addr;
    logic        flush;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [256];

    imem_responder #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .flush(flush),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr(instr), .instr_valid(instr_valid), .stall(stall)
    );

    always #5 clk = ~clk;

    // backing memory: one-cycle read latency, junk on cycles without a read
    always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 8'($urandom);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // reference model: m_fill counts the remaining fill cycles (5..1), 0 when idle;
    // the completed word is read straight out of the memory array
    int          m_fill;
    logic [7:0]  m_base, m_tag;
    logic        m_tv, m_iv;
    logic [31:0] m_line, m_instr;
    logic        m_hit;
    logic        e_stall, e_rd;
    logic [7:0]  e_addr;

    always_comb begin
        m_hit   = m_tv && addr == m_tag;
        e_stall = reset && (m_fill != 0 || (req && !m_hit && !flush));
        e_rd    = m_fill > 1;
        e_addr  = m_base + (m_fill != 0 ? 8'(5 - m_fill) : 8'd0);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_fill <= 0; m_base <= 0; m_tag <= 0; m_tv <= 0;
            m_line <= 0; m_instr <= 0; m_iv <= 0;
        end else if (flush) begin
            m_fill <= 0; m_iv <= 0;
        end else if (m_fill != 0) begin
            m_iv   <= 0;
            m_fill <= m_fill - 1;
            if (m_fill == 1) begin
                m_tv   <= 1;
                m_tag  <= m_base;
                m_line <= {mem[m_base + 8'd3], mem[m_base + 8'd2], mem[m_base + 8'd1], mem[m_base]};
            end
        end else if (req && m_hit) begin
            m_instr <= m_line;
            m_iv    <= 1;
        end else begin
            m_iv <= 0;
            if (req) begin
                m_base <= addr;
                m_fill <= 5;
            end
        end
    end

    always @(negedge clk) begin
        chk("stall", stall, e_stall);
        chk("mem_rd", mem_rd, e_rd);
        chk("mem_addr", mem_addr, e_addr);
        chk("instr_valid", instr_valid, m_iv);
        chk("instr", instr, m_instr);
    end

    // hold req on address a until accepted; report stall cycles, issued addresses, returned word
    task automatic fetch(input logic [7:0] a, output int nstall, output int nrd,
                         output logic [31:0] seq, output logic [31:0] got);
        nstall = 0; nrd = 0; seq = '0; got = '0;
        req = 1; addr = a; flush = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_rd) begin
                if (nrd < 4) seq[8*nrd +: 8] = mem_addr;
                nrd++;
            end
            if (stall) nstall++;
            else begin
                @(posedge clk); #1;
                req = 0;
                @(negedge clk);
                got = instr_valid ? instr : 32'hdeadbeef;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        req = 0;
        chk("fetch_timeout", 0, 1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ns, nr, n;
        logic [31:0] sq, gw;
        reset = 0; req = 1; addr = 0; flush = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;
        #2;
        chk("reset_stall", stall, 0);
        chk("reset_mem_rd", mem_rd, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_instr", instr, 0);
        chk("reset_valid", instr_valid, 0);
        cycles(2);
        req = 0; reset = 1;
        cycles(1);

        // cold miss
        fetch(8'h00, ns, nr, sq, gw);
        chk("cold_stall_cycles", ns, 6);
        chk("cold_reads", nr, 4);
        chk("cold_addr_seq", sq, 32'h03020100);
        chk("cold_instr", gw, 32'h00A00513);

        // hit streaming
        req = 1; addr = 0; n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk("stream_stall", stall, 0);
                chk("stream_rd", mem_rd, 0);
            end
            if (i > 0 && instr_valid) n++;
            @(posedge clk); #1;
            if (i == 3) req = 0;
        end
        chk("stream_valid_count", n, 4);

        // wrap-around
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
        fetch(8'hFE, ns, nr, sq, gw);
        chk("wrap_stall_cycles", ns, 6);
        chk("wrap_addr_seq", sq, 32'h0100FFFE);
        chk("wrap_instr", gw, 32'h44332211);

        // flush mid-fill: line holds 00, miss on 10 aborted at cnt = 2
        fetch(8'h00, ns, nr, sq, gw);
        chk("refill_00", gw, 32'h00A04433);
        req = 1; addr = 8'h10;
        @(negedge clk);
        chk("ff_miss_stall", stall, 1);
        cycles(3);
        flush = 1; req = 0;
        @(negedge clk);
        chk("ff_cnt2_addr", mem_addr, 8'h12);
        @(posedge clk); #1;
        flush = 0; req = 1; addr = 8'h00;
        @(negedge clk);
        chk("ff_idle_rd", mem_rd, 0);
        chk("ff_hit_stall", stall, 0);
        chk("ff_no_valid", instr_valid, 0);
        @(posedge clk); #1;
        req = 0;
        @(negedge clk);
        chk("ff_hit_valid", instr_valid, 1);
        chk("ff_hit_instr", instr, 32'h00A04433);
        @(posedge clk); #1;
        fetch(8'h10, ns, nr, sq, gw);
        chk("ff_remiss_stall", ns, 6);

        // flush in the completing cycle (cnt = 4): tag must not update
        req = 1; addr = 8'h20;
        cycles(5);
        flush = 1; req = 0;
        @(posedge clk); #1;
        flush = 0; req = 1; addr = 8'h20;
        @(negedge clk);
        chk("flush_cnt4_miss", stall, 1);
        @(posedge clk); #1;
        req = 0;
        cycles(6);

        // flush beats a hit
        req = 1; addr = 8'h20; flush = 1;
        @(negedge clk);
        chk("fh_stall", stall, 0);
        @(posedge clk); #1;
        req = 0; flush = 0;
        @(negedge clk);
        chk("fh_valid", instr_valid, 0);
        @(posedge clk); #1;

        // asynchronous reset at cnt = 3
        req = 1; addr = 8'h30;
        cycles(4);
        chk("ar_pre_rd", mem_rd, 1);
        chk("ar_pre_addr", mem_addr, 8'h33);
        #2 reset = 0;
        #1;
        chk("ar_mem_rd", mem_rd, 0);
        chk("ar_mem_addr", mem_addr, 0);
        chk("ar_stall", stall, 0);
        chk("ar_valid", instr_valid, 0);
        chk("ar_instr", instr, 0);
        @(posedge clk); #1;
        reset = 1; req = 0;
        cycles(1);
        fetch(8'h00, ns, nr, sq, gw);
        chk("ar_remiss_stall", ns, 6);
        chk("ar_remiss_instr", gw, 32'h00A04433);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req = $urandom_range(0, 9) < 7;
            case ($urandom_range(0, 5))
                0: addr = 8'h00;
                1: addr = 8'hFE;
                2: addr = 8'hFF;
                3: addr = 8'h10;
                4: addr = 8'h01;
                default: addr = 8'($urandom);
            endcase
            flush = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 199) == 0) #3 reset = 0;
            @(posedge clk); #1;
            reset = 1;
        end
        req = 0; flush = 0;
        cycles(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
